// File: rtl/sha_message_schedule_ctrl.sv
// SHA-256 message schedule sequencer: loads one 512-bit block, feeds the expander window and
// streams W0..W63 over valid/ready. Define SHA_MSG_SCHED_PERF_EN to add the stall_cnt_o counter.
module sha_message_schedule_ctrl #(
  parameter int EXP_LATENCY = 2,
  parameter int WORD_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   blk_valid_i,
  output logic                   blk_ready_o,
  input  logic [15:0][WORD_W-1:0] blk_i,
  output logic [15:0][WORD_W-1:0] exp_w_o,
  input  logic [15:0][WORD_W-1:0] exp_w_i,
  output logic                   w_valid_o,
  input  logic                   w_ready_i,
  output logic [WORD_W-1:0]      w_o,
  output logic [5:0]             w_idx_o,
  output logic                   busy_o,
  output logic                   done_o,
`ifdef SHA_MSG_SCHED_PERF_EN
  output logic [15:0]            stall_cnt_o,
`endif
  output logic [1:0]             dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(EXP_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(EXP_LATENCY);

  state_t                  state, state_n;
  logic [15:0][WORD_W-1:0] window, window_n;
  logic [5:0]              idx, idx_n;
  logic [CNT_W-1:0]        wcnt;
  logic                    win_wr;
  logic                    load;
  logic                    w_hs;
  logic                    settled;
  logic                    done_n, done_q;
  logic [3:0]              emit_sel;

  // Handshakes: a transfer happens on a cycle where valid && ready are both high. flush_i masks
  // both w_valid_o and blk_ready_o so an aborted cycle never looks like a transfer to either side.
  assign blk_ready_o = (state == IDLE) && !flush_i;
  assign w_valid_o   = ((state == EMIT) || (state == OUT)) && !flush_i;
  assign load        = blk_valid_i && blk_ready_o;
  assign w_hs        = w_valid_o && w_ready_i;
  assign settled     = (wcnt == CNT_MAX);

  assign emit_sel    = 4'd15 - idx[3:0];
  assign w_o         = (state == EMIT) ? window[emit_sel] : window[0];
  assign w_idx_o     = idx;
  assign exp_w_o     = window;
  assign busy_o      = (state != IDLE);
  assign done_o      = done_q;
  assign dbg_state_o = state;

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    window_n = window;
    win_wr   = 1'b0;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          for (int i = 0; i < 16; i++) window_n[i] = blk_i[15-i];
          win_wr  = 1'b1;
          idx_n   = 6'd0;
          state_n = EMIT;
        end
      end
      EMIT: begin
        // idx stays at 15 on the last message word; WAIT advances it to 16.
        if (w_hs) begin
          if (idx == 6'd15) state_n = WAIT;
          else              idx_n   = idx + 6'd1;
        end
      end
      WAIT: begin
        if (settled && !flush_i) begin
          window_n = exp_w_i;
          win_wr   = 1'b1;
          idx_n    = idx + 6'd1;
          state_n  = OUT;
        end
      end
      OUT: begin
        if (w_hs) begin
          if (idx == 6'd63) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = WAIT;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (flush_i) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      window <= '0;
      idx    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      window <= window_n;
      idx    <= idx_n;
      done_q <= done_n;
    end
  end

  // Settle counter: expander output is trustworthy once the window has been stable EXP_LATENCY cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              wcnt <= '0;
    else if (win_wr)         wcnt <= '0;
    else if (wcnt != CNT_MAX) wcnt <= wcnt + 1'b1;
  end

`ifdef SHA_MSG_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    stall_cnt_o <= '0;
    else if (load)                 stall_cnt_o <= '0;
    else if (w_valid_o && !w_ready_i && (stall_cnt_o != 16'hFFFF))
                                   stall_cnt_o <= stall_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_sha_message_schedule_ctrl.sv
// Self-checking bench for sha_message_schedule_ctrl: behavioural pipelined expander, software
// schedule model feeding an expected-word queue, and scenario tasks run in sequence.
module tb_sha_message_schedule_ctrl;
  localparam int L  = 2;
  localparam int WW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_i = 1'b0;
  logic blk_valid_i = 1'b0;
  logic w_ready_i = 1'b0;
  logic [15:0][WW-1:0] blk_i = '0;
  logic [15:0][WW-1:0] exp_w_o;
  logic [15:0][WW-1:0] exp_w_i;
  logic blk_ready_o, w_valid_o, busy_o, done_o;
  logic [WW-1:0] w_o;
  logic [5:0] w_idx_o;
  logic [1:0] dbg_state_o;
`ifdef SHA_MSG_SCHED_PERF_EN
  logic [15:0] stall_cnt_o;
  logic [15:0] stall_at_done = '0;
`endif

  int checks = 0;
  int errors = 0;
  logic [WW-1:0] exp_q[$];
  logic [5:0]    idx_q[$];
  int cyc = 0, load_cyc = 0, load_count = 0, done_count = 0, done_cyc = 0, hs_count = 0;
  int hs_cyc[64];
  logic [WW-1:0] got_w[64];
  int cons_mode = 0;
  int stall_left = 0;
  bit trig3 = 0, trig40 = 0;
  bit prev_stall = 0;
  logic [WW-1:0] prev_w;
  logic [5:0] prev_idx;
  logic [15:0][WW-1:0] abc_blk;

  sha_message_schedule_ctrl #(.EXP_LATENCY(L), .WORD_W(WW)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o), .blk_i(blk_i),
    .exp_w_o(exp_w_o), .exp_w_i(exp_w_i),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_o(w_o), .w_idx_o(w_idx_o),
    .busy_o(busy_o), .done_o(done_o),
`ifdef SHA_MSG_SCHED_PERF_EN
    .stall_cnt_o(stall_cnt_o),
`endif
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d, required finish", cyc);
    $fatal(1);
  end

  // ---------------- SHA-256 helpers ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [15:0][WW-1:0] expand(input logic [15:0][WW-1:0] w);
    logic [15:0][WW-1:0] r;
    r[15:1] = w[14:0];
    r[0]    = s1(w[1]) + w[6] + s0(w[14]) + w[15];
    return r;
  endfunction
  function automatic logic [15:0][WW-1:0] rand_blk();
    logic [15:0][WW-1:0] b;
    for (int i = 0; i < 16; i++) b[i] = $urandom;
    return b;
  endfunction

  // Behavioural expander with L register stages.
  logic [15:0][WW-1:0] pipe [L];
  always @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= expand(exp_w_o);
  end
  assign exp_w_i = pipe[L-1];

  // Software schedule model -> expected queue.
  task automatic push_block(input logic [15:0][WW-1:0] b);
    logic [WW-1:0] w[64];
    for (int t = 0; t < 16; t++) w[t] = b[t];
    for (int t = 16; t < 64; t++) w[t] = s1(w[t-2]) + w[t-7] + s0(w[t-15]) + w[t-16];
    for (int t = 0; t < 64; t++) begin
      exp_q.push_back(w[t]);
      idx_q.push_back(6'(t));
    end
  endtask

  // ---------------- consumer (drives w_ready_i) ----------------
  always @(posedge clk) begin
    #1;
    if (cons_mode == 1) begin
      w_ready_i = 1'($urandom_range(0, 1));
    end else if (cons_mode == 2) begin
      if (w_valid_o && w_idx_o == 6'd3 && !trig3) begin trig3 = 1; stall_left = 5; end
      if (w_valid_o && w_idx_o == 6'd40 && !trig40) begin trig40 = 1; stall_left = 7; end
      if (stall_left > 0) begin w_ready_i = 1'b0; stall_left--; end
      else w_ready_i = 1'b1;
    end else begin
      w_ready_i = 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (blk_valid_i && blk_ready_o) begin
        load_cyc = cyc;
        load_count++;
        push_block(blk_i);
      end
      if (busy_o) begin
        checks++;
        if (blk_ready_o !== 1'b0) begin
          errors++;
          $display("FAIL ready_while_busy cycle %0d got blk_ready_o=%b want 0", cyc, blk_ready_o);
        end
      end
      if (w_valid_o && w_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word cycle %0d got idx %0d w %h want no word", cyc, w_idx_o, w_o);
        end else begin
          logic [WW-1:0] e;
          logic [5:0] ei;
          e  = exp_q.pop_front();
          ei = idx_q.pop_front();
          if (w_o !== e || w_idx_o !== ei) begin
            errors++;
            $display("FAIL word cycle %0d got idx %0d w %h want idx %0d w %h", cyc, w_idx_o, w_o, ei, e);
          end
          hs_cyc[w_idx_o] = cyc;
          got_w[w_idx_o]  = w_o;
          hs_count++;
        end
      end
      if (prev_stall && w_valid_o) begin
        checks++;
        if (w_o !== prev_w || w_idx_o !== prev_idx) begin
          errors++;
          $display("FAIL stall_stable cycle %0d got idx %0d w %h want idx %0d w %h",
                   cyc, w_idx_o, w_o, prev_idx, prev_w);
        end
      end
      prev_stall = w_valid_o && !w_ready_i;
      prev_w     = w_o;
      prev_idx   = w_idx_o;
      if (done_o) begin
        done_count++;
        done_cyc = cyc;
`ifdef SHA_MSG_SCHED_PERF_EN
        stall_at_done = stall_cnt_o;
`endif
      end
    end else begin
      prev_stall = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_block(input logic [15:0][WW-1:0] b);
    int start;
    int n;
    start = load_count;
    n = 0;
    @(posedge clk); #1;
    blk_i = b;
    blk_valid_i = 1'b1;
    while (load_count == start && n < 50) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    blk_valid_i = 1'b0;
    checks++;
    if (load_count == start) begin
      errors++;
      $display("FAIL load_accept got loads %0d want %0d", load_count, start + 1);
    end
  endtask

  task automatic wait_done(input int want, input int budget);
    int n;
    n = 0;
    while (done_count < want && n < budget) begin @(negedge clk); #1; n++; end
    checks++;
    if (done_count < want) begin
      errors++;
      $display("FAIL done_timeout got done count %0d want %0d", done_count, want);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained got %0d words left want 0", name, exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({w_valid_o, done_o, busy_o, blk_ready_o} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_flags got valid/done/busy/ready %b want 0001",
               {w_valid_o, done_o, busy_o, blk_ready_o});
    end
    checks++;
    if (exp_w_o !== '0 || w_idx_o !== 6'd0) begin
      errors++;
      $display("FAIL reset_window got idx %0d window %h want 0 and zero", w_idx_o, exp_w_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_abc();
    int d0;
    d0 = done_count;
    cons_mode = 0;
    load_block(abc_blk);
    wait_done(d0 + 1, 400);
    check_drained("abc");
    checks++;
    if (done_cyc - load_cyc != 160) begin
      errors++;
      $display("FAIL abc_latency got %0d want 160", done_cyc - load_cyc);
    end
    checks++;
    if (hs_cyc[0] - load_cyc != 1 || hs_cyc[15] - load_cyc != 16 || hs_cyc[16] - load_cyc != 18) begin
      errors++;
      $display("FAIL abc_timing got W0/W15/W16 at %0d/%0d/%0d want 1/16/18",
               hs_cyc[0] - load_cyc, hs_cyc[15] - load_cyc, hs_cyc[16] - load_cyc);
    end
    checks++;
    if (got_w[16] !== 32'h61626380 || got_w[17] !== 32'h000F0000) begin
      errors++;
      $display("FAIL abc_w16_w17 got %h %h want 61626380 000f0000", got_w[16], got_w[17]);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (done_count != d0 + 1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL abc_single_done got dones %0d busy %b want %0d and 0", done_count - d0, busy_o, 1);
    end
  endtask

  task automatic test_random_stall();
    int d0;
    int h0;
    d0 = done_count;
    h0 = hs_count;
    cons_mode = 1;
    load_block(abc_blk);
    wait_done(d0 + 1, 3000);
    cons_mode = 0;
    check_drained("random_stall");
    checks++;
    if (hs_count - h0 != 64) begin
      errors++;
      $display("FAIL random_stall_count got %0d words want 64", hs_count - h0);
    end
  endtask

  task automatic test_flush();
    int d0;
    int n;
    d0 = done_count;
    n = 0;
    cons_mode = 0;
    load_block(rand_blk());
    @(posedge clk); #1;
    while (!(w_valid_o && w_idx_o == 6'd37) && n < 400) begin @(posedge clk); #1; n++; end
    flush_i = 1'b1;
    #1;
    checks++;
    if (w_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_valid got w_valid_o %b want 0", w_valid_o);
    end
    @(posedge clk); #1;
    flush_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || blk_ready_o !== 1'b1 || dbg_state_o !== 2'd0) begin
      errors++;
      $display("FAIL flush_idle got busy %b ready %b state %0d want 0 1 0", busy_o, blk_ready_o, dbg_state_o);
    end
    checks++;
    if (exp_q.size() != 27) begin
      errors++;
      $display("FAIL flush_no_w37 got %0d words left want 27", exp_q.size());
    end
    exp_q.delete();
    idx_q.delete();
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (done_count != d0) begin
      errors++;
      $display("FAIL flush_no_done got %0d pulses want 0", done_count - d0);
    end
    load_block(rand_blk());
    wait_done(d0 + 1, 400);
    check_drained("flush_restart");
  endtask

  task automatic test_reset_mid();
    int d0;
    int n;
    d0 = done_count;
    n = 0;
    cons_mode = 0;
    load_block(rand_blk());
    @(posedge clk); #1;
    while (!(dbg_state_o == 2'd2 && w_idx_o == 6'd20) && n < 400) begin @(posedge clk); #1; n++; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({w_valid_o, done_o, busy_o, blk_ready_o} !== 4'b0001 || w_idx_o !== 6'd0 || exp_w_o !== '0) begin
      errors++;
      $display("FAIL reset_mid got valid/done/busy/ready %b idx %0d want 0001 idx 0 zero window",
               {w_valid_o, done_o, busy_o, blk_ready_o}, w_idx_o);
    end
    exp_q.delete();
    idx_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    load_block(rand_blk());
    wait_done(d0 + 1, 400);
    check_drained("reset_restart");
  endtask

  task automatic test_back_to_back();
    int d0;
    int l0;
    int n;
    int dc1;
    logic [15:0][WW-1:0] b2;
    d0 = done_count;
    l0 = load_count;
    n = 0;
    b2 = rand_blk();
    cons_mode = 0;
    @(posedge clk); #1;
    blk_i = rand_blk();
    blk_valid_i = 1'b1;
    while (load_count == l0 && n < 50) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    blk_i = b2;
    wait_done(d0 + 1, 400);
    dc1 = done_cyc;
    n = 0;
    while (load_count < l0 + 2 && n < 50) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    blk_valid_i = 1'b0;
    checks++;
    if (load_count != l0 + 2 || load_cyc != dc1) begin
      errors++;
      $display("FAIL b2b_reload got loads %0d at cycle %0d want %0d at cycle %0d",
               load_count - l0, load_cyc, 2, dc1);
    end
    wait_done(d0 + 2, 400);
    repeat (5) @(posedge clk);
    #1;
    check_drained("b2b");
    checks++;
    if (load_count != l0 + 2) begin
      errors++;
      $display("FAIL b2b_load_count got %0d want 2", load_count - l0);
    end
  endtask

`ifdef SHA_MSG_SCHED_PERF_EN
  task automatic test_perf();
    int d0;
    d0 = done_count;
    trig3 = 0;
    trig40 = 0;
    stall_left = 0;
    cons_mode = 2;
    load_block(abc_blk);
    wait_done(d0 + 1, 600);
    cons_mode = 0;
    check_drained("perf");
    checks++;
    if (stall_at_done !== 16'd12) begin
      errors++;
      $display("FAIL perf_stall_cnt got %0d want 12", stall_at_done);
    end
  endtask
`endif

  initial begin
    abc_blk     = '0;
    abc_blk[0]  = 32'h61626380;
    abc_blk[15] = 32'h00000018;
    test_reset();
    test_abc();
    test_random_stall();
    test_flush();
    test_reset_mid();
    test_back_to_back();
`ifdef SHA_MSG_SCHED_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
